// File: rtl/rs_age_issue_queue.sv
// Age-ordered reservation station for one functional unit: dispatch into any free slot,
// CDB wakeup (including capture in the dispatch cycle), oldest-ready issue, single-cycle flush.
module rs_age_issue_queue #(
  parameter int RS_ENTRIES  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = 6,
  parameter int NUM_WB      = 2,
  parameter int INSTR_WIDTH = 32,
  parameter int CNT_WIDTH   = $clog2(RS_ENTRIES + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          dispatch_valid,
  output logic                          dispatch_ready,
  input  logic [INSTR_WIDTH-1:0]        dispatch_instr,
  input  logic [TAG_WIDTH-1:0]          dispatch_dest_tag,
  input  logic [DATA_WIDTH-1:0]         dispatch_rs1_data,
  input  logic [DATA_WIDTH-1:0]         dispatch_rs2_data,
  input  logic                          dispatch_rs1_ready,
  input  logic                          dispatch_rs2_ready,
  input  logic [TAG_WIDTH-1:0]          dispatch_rs1_tag,
  input  logic [TAG_WIDTH-1:0]          dispatch_rs2_tag,
  input  logic [NUM_WB-1:0]             wb_valid,
  input  logic [NUM_WB*TAG_WIDTH-1:0]   wb_tag,
  input  logic [NUM_WB*DATA_WIDTH-1:0]  wb_data,
  output logic                          exec_valid,
  input  logic                          exec_ready,
  output logic [INSTR_WIDTH-1:0]        exec_instr,
  output logic [TAG_WIDTH-1:0]          exec_dest_tag,
  output logic [DATA_WIDTH-1:0]         exec_rs1_data,
  output logic [DATA_WIDTH-1:0]         exec_rs2_data,
  output logic [CNT_WIDTH-1:0]          occupancy
);

  typedef struct packed {
    logic                  hit;
    logic [DATA_WIDTH-1:0] data;
  } wb_match_t;

  // Scanning from the highest port down lets the lowest matching port win.
  function automatic wb_match_t wbLookup(input logic [TAG_WIDTH-1:0]         tag,
                                         input logic [NUM_WB-1:0]            vld,
                                         input logic [NUM_WB*TAG_WIDTH-1:0]  tags,
                                         input logic [NUM_WB*DATA_WIDTH-1:0] datas);
    wb_match_t m;
    m = '0;
    for (int p = NUM_WB - 1; p >= 0; p--) begin
      if (vld[p] && (tags[p*TAG_WIDTH +: TAG_WIDTH] == tag)) begin
        m.hit  = 1'b1;
        m.data = datas[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    return m;
  endfunction

  logic [RS_ENTRIES-1:0]  valid_q, valid_d;
  logic [RS_ENTRIES-1:0]  rs1Ready_q, rs1Ready_d, rs2Ready_q, rs2Ready_d;
  logic [TAG_WIDTH-1:0]   rs1Tag_q [RS_ENTRIES];
  logic [TAG_WIDTH-1:0]   rs1Tag_d [RS_ENTRIES];
  logic [TAG_WIDTH-1:0]   rs2Tag_q [RS_ENTRIES];
  logic [TAG_WIDTH-1:0]   rs2Tag_d [RS_ENTRIES];
  logic [DATA_WIDTH-1:0]  rs1Data_q [RS_ENTRIES];
  logic [DATA_WIDTH-1:0]  rs1Data_d [RS_ENTRIES];
  logic [DATA_WIDTH-1:0]  rs2Data_q [RS_ENTRIES];
  logic [DATA_WIDTH-1:0]  rs2Data_d [RS_ENTRIES];
  logic [INSTR_WIDTH-1:0] instr_q [RS_ENTRIES];
  logic [INSTR_WIDTH-1:0] instr_d [RS_ENTRIES];
  logic [TAG_WIDTH-1:0]   dest_q [RS_ENTRIES];
  logic [TAG_WIDTH-1:0]   dest_d [RS_ENTRIES];
  logic [RS_ENTRIES-1:0]  older_q [RS_ENTRIES];
  logic [RS_ENTRIES-1:0]  older_d [RS_ENTRIES];
  logic [CNT_WIDTH-1:0]   occ_q, occ_d;

  logic [RS_ENTRIES-1:0]  eligible, select, allocOh;
  logic                   dispatchFire, issueFire;
  wb_match_t              disp1, disp2;
  wb_match_t              wake1 [RS_ENTRIES];
  wb_match_t              wake2 [RS_ENTRIES];

  assign eligible       = valid_q & rs1Ready_q & rs2Ready_q;
  assign exec_valid     = (|eligible) && !flush;
  assign issueFire      = exec_valid && exec_ready;
  assign dispatch_ready = (occ_q < CNT_WIDTH'(RS_ENTRIES)) && !flush;
  assign dispatchFire   = dispatch_valid && dispatch_ready;
  assign occupancy      = occ_q;

  // An eligible entry is selected only if it is older than every other eligible entry.
  always_comb begin
    select = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      select[i] = eligible[i];
      for (int j = 0; j < RS_ENTRIES; j++) begin
        if ((j != i) && eligible[j] && !older_q[i][j]) select[i] = 1'b0;
      end
    end
  end

  always_comb begin
    exec_instr    = '0;
    exec_dest_tag = '0;
    exec_rs1_data = '0;
    exec_rs2_data = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      if (select[i]) begin
        exec_instr    = exec_instr | instr_q[i];
        exec_dest_tag = exec_dest_tag | dest_q[i];
        exec_rs1_data = exec_rs1_data | rs1Data_q[i];
        exec_rs2_data = exec_rs2_data | rs2Data_q[i];
      end
    end
  end

  always_comb begin
    allocOh = '0;
    for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        allocOh    = '0;
        allocOh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    disp1 = wbLookup(dispatch_rs1_tag, wb_valid, wb_tag, wb_data);
    disp2 = wbLookup(dispatch_rs2_tag, wb_valid, wb_tag, wb_data);
    for (int i = 0; i < RS_ENTRIES; i++) begin
      wake1[i] = wbLookup(rs1Tag_q[i], wb_valid, wb_tag, wb_data);
      wake2[i] = wbLookup(rs2Tag_q[i], wb_valid, wb_tag, wb_data);
    end
  end

  always_comb begin
    valid_d    = valid_q;
    rs1Ready_d = rs1Ready_q;
    rs2Ready_d = rs2Ready_q;
    rs1Tag_d   = rs1Tag_q;
    rs2Tag_d   = rs2Tag_q;
    rs1Data_d  = rs1Data_q;
    rs2Data_d  = rs2Data_q;
    instr_d    = instr_q;
    dest_d     = dest_q;
    older_d    = older_q;
    occ_d      = occ_q + CNT_WIDTH'(dispatchFire) - CNT_WIDTH'(issueFire);
    for (int i = 0; i < RS_ENTRIES; i++) begin
      if (valid_q[i] && !rs1Ready_q[i] && wake1[i].hit) begin
        rs1Ready_d[i] = 1'b1;
        rs1Data_d[i]  = wake1[i].data;
      end
      if (valid_q[i] && !rs2Ready_q[i] && wake2[i].hit) begin
        rs2Ready_d[i] = 1'b1;
        rs2Data_d[i]  = wake2[i].data;
      end
      if (issueFire && select[i]) valid_d[i] = 1'b0;
      // The new entry is younger than everything already resident.
      if (dispatchFire && allocOh[i]) begin
        valid_d[i]    = 1'b1;
        instr_d[i]    = dispatch_instr;
        dest_d[i]     = dispatch_dest_tag;
        rs1Tag_d[i]   = dispatch_rs1_tag;
        rs2Tag_d[i]   = dispatch_rs2_tag;
        rs1Ready_d[i] = dispatch_rs1_ready || disp1.hit;
        rs2Ready_d[i] = dispatch_rs2_ready || disp2.hit;
        rs1Data_d[i]  = dispatch_rs1_ready ? dispatch_rs1_data : disp1.data;
        rs2Data_d[i]  = dispatch_rs2_ready ? dispatch_rs2_data : disp2.data;
        older_d[i]    = '0;
        for (int j = 0; j < RS_ENTRIES; j++) begin
          if (valid_q[j]) older_d[j][i] = 1'b1;
        end
      end
    end
    if (flush) begin
      valid_d = '0;
      occ_d   = '0;
      for (int i = 0; i < RS_ENTRIES; i++) older_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      rs1Ready_q <= '0;
      rs2Ready_q <= '0;
      occ_q      <= '0;
      for (int i = 0; i < RS_ENTRIES; i++) begin
        rs1Tag_q[i]  <= '0;
        rs2Tag_q[i]  <= '0;
        rs1Data_q[i] <= '0;
        rs2Data_q[i] <= '0;
        instr_q[i]   <= '0;
        dest_q[i]    <= '0;
        older_q[i]   <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      rs1Ready_q <= rs1Ready_d;
      rs2Ready_q <= rs2Ready_d;
      occ_q      <= occ_d;
      rs1Tag_q   <= rs1Tag_d;
      rs2Tag_q   <= rs2Tag_d;
      rs1Data_q  <= rs1Data_d;
      rs2Data_q  <= rs2Data_d;
      instr_q    <= instr_d;
      dest_q     <= dest_d;
      older_q    <= older_d;
    end
  end

endmodule

// File: tb/tb_rs_age_issue_queue.sv
// Directed bench for rs_age_issue_queue: stimulus pushes the expected issue order into a
// queue and an independent monitor pops and compares on every exec handshake.
module tb_rs_age_issue_queue;

  localparam int N   = 8;
  localparam int DW  = 32;
  localparam int TW  = 6;
  localparam int NWB = 2;
  localparam int IW  = 32;
  localparam int CW  = $clog2(N + 1);

  logic              clk, rst_n, flush;
  logic              dispatch_valid, dispatch_ready;
  logic [IW-1:0]     dispatch_instr;
  logic [TW-1:0]     dispatch_dest_tag, dispatch_rs1_tag, dispatch_rs2_tag;
  logic [DW-1:0]     dispatch_rs1_data, dispatch_rs2_data;
  logic              dispatch_rs1_ready, dispatch_rs2_ready;
  logic [NWB-1:0]    wb_valid;
  logic [NWB*TW-1:0] wb_tag;
  logic [NWB*DW-1:0] wb_data;
  logic              exec_valid, exec_ready;
  logic [IW-1:0]     exec_instr;
  logic [TW-1:0]     exec_dest_tag;
  logic [DW-1:0]     exec_rs1_data, exec_rs2_data;
  logic [CW-1:0]     occupancy;

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [TW-1:0] dest;
    logic [DW-1:0] rs1;
    logic [DW-1:0] rs2;
  } issue_t;

  issue_t expQ[$];
  issue_t monExp;
  int     vectors = 0;
  int     miscompares = 0;

  rs_age_issue_queue #(
    .RS_ENTRIES(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .NUM_WB(NWB), .INSTR_WIDTH(IW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_instr(dispatch_instr), .dispatch_dest_tag(dispatch_dest_tag),
    .dispatch_rs1_data(dispatch_rs1_data), .dispatch_rs2_data(dispatch_rs2_data),
    .dispatch_rs1_ready(dispatch_rs1_ready), .dispatch_rs2_ready(dispatch_rs2_ready),
    .dispatch_rs1_tag(dispatch_rs1_tag), .dispatch_rs2_tag(dispatch_rs2_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .exec_valid(exec_valid), .exec_ready(exec_ready),
    .exec_instr(exec_instr), .exec_dest_tag(exec_dest_tag),
    .exec_rs1_data(exec_rs1_data), .exec_rs2_data(exec_rs2_data),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic dv, input logic [IW-1:0] instr, input logic [TW-1:0] dest,
                               input logic r1, input logic [TW-1:0] t1, input logic [DW-1:0] d1,
                               input logic r2, input logic [TW-1:0] t2, input logic [DW-1:0] d2);
    dispatch_valid     = dv;
    dispatch_instr     = instr;
    dispatch_dest_tag  = dest;
    dispatch_rs1_ready = r1;
    dispatch_rs1_tag   = t1;
    dispatch_rs1_data  = d1;
    dispatch_rs2_ready = r2;
    dispatch_rs2_tag   = t2;
    dispatch_rs2_data  = d2;
  endtask

  task automatic setWb(input logic [1:0] v, input logic [TW-1:0] ta, input logic [DW-1:0] da,
                       input logic [TW-1:0] tb, input logic [DW-1:0] db);
    wb_valid = v;
    wb_tag   = {tb, ta};
    wb_data  = {db, da};
  endtask

  // Every accepted issue must match the next entry the stimulus predicted.
  always @(negedge clk) begin
    if (rst_n && exec_valid && exec_ready) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_issue: got instr 0x%0h, expected no issue", exec_instr);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("issue", {exec_instr, exec_dest_tag, exec_rs1_data, exec_rs2_data}, monExp);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    exec_ready = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    setWb(0, 0, 0, 0, 0);
    tick();
    checkOutput("reset_occupancy", occupancy, 0);
    checkOutput("reset_exec_valid", exec_valid, 0);
    checkOutput("reset_exec_rs1", exec_rs1_data, 0);
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("reset_dispatch_ready", dispatch_ready, 1);

    // Single ready uop: visible one cycle after dispatch.
    applyStimulus(1, 'hA, 1, 1, 0, 1, 1, 0, 2);
    tick();
    dispatch_valid = 1'b0;
    #1;
    checkOutput("t1_exec_valid", exec_valid, 1);
    checkOutput("t1_occupancy", occupancy, 1);
    checkOutput("t1_rs1", exec_rs1_data, 1);
    checkOutput("t1_rs2", exec_rs2_data, 2);
    expQ.push_back({32'hA, 6'd1, 32'd1, 32'd2});
    exec_ready = 1'b1;
    tick();
    exec_ready = 1'b0;
    #1;
    checkOutput("t1_occ_after", occupancy, 0);
    checkOutput("t1_exec_valid_after", exec_valid, 0);

    // Younger ready uop bypasses an older waiting one; CDB port 1 wakes the older one.
    applyStimulus(1, 'h20, 2, 0, 5, 0, 1, 0, 'h7);
    tick();
    applyStimulus(1, 'h21, 3, 1, 0, 'h3, 1, 0, 'h4);
    tick();
    dispatch_valid = 1'b0;
    expQ.push_back({32'h21, 6'd3, 32'h3, 32'h4});
    exec_ready = 1'b1;
    tick();
    #1;
    checkOutput("t2_waiting_not_valid", exec_valid, 0);
    checkOutput("t2_occupancy", occupancy, 1);
    expQ.push_back({32'h20, 6'd2, 32'h55, 32'h7});
    setWb(2'b10, 0, 0, 5, 'h55);
    tick();
    setWb(0, 0, 0, 0, 0);
    tick();
    exec_ready = 1'b0;
    #1;
    checkOutput("t2_occ_after", occupancy, 0);

    // Age beats slot index: D lands in slot 0 after C, yet C issues first.
    applyStimulus(1, 'h30, 4, 0, 7, 0, 1, 0, 'h3);
    tick();
    applyStimulus(1, 'h31, 5, 0, 8, 0, 1, 0, 'h4);
    tick();
    applyStimulus(1, 'h32, 6, 1, 0, 'hC1, 1, 0, 'hC2);
    tick();
    dispatch_valid = 1'b0;
    setWb(2'b01, 7, 'h70, 0, 0);
    tick();
    setWb(0, 0, 0, 0, 0);
    #1;
    checkOutput("t3_oldest_first", exec_instr, 'h30);
    expQ.push_back({32'h30, 6'd4, 32'h70, 32'h3});
    exec_ready = 1'b1;
    tick();
    exec_ready = 1'b0;
    applyStimulus(1, 'h33, 7, 1, 0, 'hD1, 1, 0, 'hD2);
    tick();
    dispatch_valid = 1'b0;
    #1;
    checkOutput("t3_occupancy", occupancy, 3);
    checkOutput("t3_c_before_d", exec_instr, 'h32);
    expQ.push_back({32'h32, 6'd6, 32'hC1, 32'hC2});
    expQ.push_back({32'h33, 6'd7, 32'hD1, 32'hD2});
    exec_ready = 1'b1;
    tick();
    tick();
    #1;
    checkOutput("t3_y_waiting", exec_valid, 0);
    expQ.push_back({32'h31, 6'd5, 32'h80, 32'h4});
    setWb(2'b10, 0, 0, 8, 'h80);
    tick();
    setWb(0, 0, 0, 0, 0);
    tick();
    exec_ready = 1'b0;
    #1;
    checkOutput("t3_occ_after", occupancy, 0);

    // Dispatch-cycle capture, and lowest port wins when both ports match.
    applyStimulus(1, 'h40, 8, 1, 0, 'h4, 0, 9, 0);
    setWb(2'b01, 9, 'h99, 0, 0);
    tick();
    applyStimulus(1, 'h41, 9, 0, 9, 0, 1, 0, 'h5);
    setWb(2'b11, 9, 'h11, 9, 'h22);
    tick();
    dispatch_valid = 1'b0;
    setWb(0, 0, 0, 0, 0);
    #1;
    checkOutput("t4_exec_valid", exec_valid, 1);
    checkOutput("t4_captured_rs2", exec_rs2_data, 'h99);
    expQ.push_back({32'h40, 6'd8, 32'h4, 32'h99});
    expQ.push_back({32'h41, 6'd9, 32'h11, 32'h5});
    exec_ready = 1'b1;
    tick();
    tick();
    exec_ready = 1'b0;
    #1;
    checkOutput("t4_occ_after", occupancy, 0);

    // Full queue: extra dispatch ignored; a slot freed by issue is reusable only next cycle.
    for (int i = 0; i < N; i++) begin
      applyStimulus(1, IW'('h50 + i), TW'(i), 0, TW'('h10 + i), 0, 1, 0, DW'('h100 + i));
      tick();
    end
    dispatch_valid = 1'b0;
    #1;
    checkOutput("t5_full_ready", dispatch_ready, 0);
    checkOutput("t5_full_occ", occupancy, 8);
    checkOutput("t5_none_eligible", exec_valid, 0);
    applyStimulus(1, 'h5F, 0, 1, 0, 'hF, 1, 0, 'hF);
    tick();
    dispatch_valid = 1'b0;
    #1;
    checkOutput("t5_extra_ignored", occupancy, 8);
    setWb(2'b01, 'h13, 'h33, 0, 0);
    tick();
    setWb(0, 0, 0, 0, 0);
    expQ.push_back({32'h53, 6'd3, 32'h33, 32'h103});
    applyStimulus(1, 'h60, 'h3F, 1, 0, 'h6, 1, 0, 'h7);
    exec_ready = 1'b1;
    #1;
    checkOutput("t5_no_same_cycle_reuse", dispatch_ready, 0);
    tick();
    exec_ready = 1'b0;
    #1;
    checkOutput("t5_ready_after_issue", dispatch_ready, 1);
    checkOutput("t5_occ_after_issue", occupancy, 7);
    tick();
    dispatch_valid = 1'b0;
    #1;
    checkOutput("t5_refilled", occupancy, 8);
    checkOutput("t5_new_entry_selected", exec_instr, 'h60);

    flush = 1'b1;
    exec_ready = 1'b1;
    #1;
    checkOutput("t5_flush_exec_valid", exec_valid, 0);
    tick();
    flush = 1'b0;
    exec_ready = 1'b0;
    #1;
    checkOutput("t5_flush_occ", occupancy, 0);

    // Flush with ready entries and an eager consumer: nothing issues, stale tags wake nothing.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, IW'('h70 + i), TW'(i), 0, TW'('h20 + i), 0, 1, 0, 1);
      tick();
    end
    applyStimulus(1, 'h73, 3, 1, 0, 1, 1, 0, 1);
    tick();
    applyStimulus(1, 'h74, 4, 1, 0, 2, 1, 0, 2);
    tick();
    dispatch_valid = 1'b0;
    #1;
    checkOutput("t6_occupancy", occupancy, 5);
    checkOutput("t6_exec_valid_pre", exec_valid, 1);
    flush = 1'b1;
    exec_ready = 1'b1;
    #1;
    checkOutput("t6_flush_exec_valid", exec_valid, 0);
    checkOutput("t6_flush_dispatch_ready", dispatch_ready, 0);
    tick();
    flush = 1'b0;
    #1;
    checkOutput("t6_occ_after", occupancy, 0);
    checkOutput("t6_ready_after", dispatch_ready, 1);
    checkOutput("t6_exec_valid_after", exec_valid, 0);
    setWb(2'b11, 'h20, 1, 'h21, 2);
    tick();
    setWb(2'b01, 'h22, 3, 0, 0);
    tick();
    setWb(0, 0, 0, 0, 0);
    #1;
    checkOutput("t6_no_wakeup", exec_valid, 0);
    checkOutput("t6_still_empty", occupancy, 0);
    exec_ready = 1'b0;

    tick();
    tick();
    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
